// File: rtl/truth_table_sweeper.sv
// Walks every input vector of an N-input combinational pair, holding each for DWELL cycles,
// and compares the two implementations' outputs on the last cycle of each hold.
module truth_table_sweeper #(
  parameter int unsigned N_INPUTS = 3,
  parameter int unsigned DWELL    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                y_a,
  input  logic                y_b,
  output logic [N_INPUTS-1:0] vec,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                mismatch,
  output logic [N_INPUTS:0]   mismatch_count,
  output logic [N_INPUTS-1:0] first_fail_vec,
  output logic                first_fail_vld
);

  localparam int unsigned CW  = N_INPUTS + 1;
  localparam int unsigned DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [N_INPUTS-1:0] VEC_LAST   = '1;
  localparam logic [DCW-1:0]      DWELL_LAST = DCW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [DCW-1:0]      dwell_cnt, dwell_cnt_d;
  logic [N_INPUTS-1:0] vec_d;
  logic                busy_d, done_d, pass_d, mismatch_d;
  logic [CW-1:0]       mismatch_count_d;
  logic [N_INPUTS-1:0] first_fail_vec_d;
  logic                first_fail_vld_d;
  logic                fail;

  // State and all outputs are registered; reset wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      dwell_cnt      <= '0;
      vec            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch       <= 1'b0;
      mismatch_count <= '0;
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      state          <= state_d;
      dwell_cnt      <= dwell_cnt_d;
      vec            <= vec_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      mismatch       <= mismatch_d;
      mismatch_count <= mismatch_count_d;
      first_fail_vec <= first_fail_vec_d;
      first_fail_vld <= first_fail_vld_d;
    end
  end

  // Next-state and next-output logic; everything holds unless changed below.
  always_comb begin
    state_d          = state;
    dwell_cnt_d      = dwell_cnt;
    vec_d            = vec;
    busy_d           = busy;
    done_d           = done;
    pass_d           = pass;
    mismatch_d       = 1'b0;
    mismatch_count_d = mismatch_count;
    first_fail_vec_d = first_fail_vec;
    first_fail_vld_d = first_fail_vld;
    fail             = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d          = DRIVE;
          vec_d            = '0;
          dwell_cnt_d      = '0;
          busy_d           = 1'b1;
          done_d           = 1'b0;
          pass_d           = 1'b0;
          mismatch_count_d = '0;
          first_fail_vec_d = '0;
          first_fail_vld_d = 1'b0;
        end
      end
      DRIVE: begin
        if (dwell_cnt != DWELL_LAST) begin
          dwell_cnt_d = dwell_cnt + DCW'(1);
        end else begin
          fail             = (y_a != y_b);
          mismatch_d       = fail;
          mismatch_count_d = mismatch_count + CW'(fail);
          if (fail && !first_fail_vld) begin
            first_fail_vec_d = vec;
            first_fail_vld_d = 1'b1;
          end
          if (vec != VEC_LAST) begin
            vec_d       = vec + N_INPUTS'(1);
            dwell_cnt_d = '0;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mismatch_count_d == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
